// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder slice processes operands LSB-first, one
// bit per clock, with the slice carry registered and fed back. A start/busy/
// done handshake frames each operation; sum, carryout and overflow hold the
// last completed result until the next operation completes.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  // The single full-adder slice working on the current LSBs and stored carry.
  logic bit_s;
  logic bit_c;
  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

  // Next-state logic: operand capture, per-bit shifting and result publication.
  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    s_sr_d     = s_sr_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE so operations can run back-to-back.
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = carryin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_sr_d = {bit_s, s_sr_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        c_d    = bit_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB, c_q is the carry into the MSB, so its XOR with the
          // carry out gives two's-complement overflow.
          sum_d      = {bit_s, s_sr_q[WIDTH-1:1]};
          carryout_d = bit_c;
          overflow_d = c_q ^ bit_c;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      s_sr_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      s_sr_q     <= s_sr_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule
